// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR block: controller state encoding and the
// default geometry used by fir_seq_ctrl, shift_register, coeffs_regs and fir.
// ---------------------------------------------------------------------------
package fir_pkg;

    // Default geometry of the FIR datapath.
    localparam int FIR_NUM_COEFF = 4;   // taps / coefficient slots / flush length
    localparam int FIR_SIZE      = 8;   // sample, coefficient and result width
    localparam int FIR_COEFF_W   = 5;   // width of incoming coefficient data
    localparam int FIR_SEL_W     = 2;   // coefficient select width
    localparam int FIR_DIV_W     = 24;  // sample-rate divider width

    // Controller state; the encoding is visible on debug probes, keep it fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } fir_state_t;

endpackage : fir_pkg

// File: rtl/fir_tick_gen.sv
// ---------------------------------------------------------------------------
// fir_tick_gen
// Loadable down-counter that paces sample shifts. A load sets both the
// current count and the reload value. While enabled, the counter decrements
// every cycle; when it sits at zero, tick is asserted and the counter
// reloads, so the tick period is reload value + 1 cycles.
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (count and reload cleared)
//   load     load count and reload value from load_val (overrides en)
//   load_val value to load (period - 1)
//   en       count enable
//   tick     combinational: counter at zero while enabled
// ---------------------------------------------------------------------------
module fir_tick_gen
    import fir_pkg::*;
#(
    parameter int DIV_W = FIR_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;
    logic [DIV_W-1:0] count_next;
    logic [DIV_W-1:0] reload_reg;
    logic [DIV_W-1:0] reload_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            reload_reg <= '0;
        end else begin
            count_reg  <= count_next;
            reload_reg <= reload_next;
        end
    end

    always_comb begin
        count_next  = count_reg;
        reload_next = reload_reg;
        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
        end else if (en) begin
            // Reload at zero instead of wrapping.
            if (count_reg == '0) begin
                count_next = reload_reg;
            end else begin
                count_next = count_reg - DIV_W'(1);
            end
        end
    end

    assign tick = en && !load && (count_reg == '0);

endmodule : fir_tick_gen

// File: rtl/fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fir_seq_ctrl
// Sequencer for the FIR datapath. Loads the coefficient bank through a
// ready/valid port, paces tap-register shifts with a programmable divider,
// captures the combinational FIR result one cycle after each shift, and on
// stop pushes NUM_COEFF zeros through the delay line.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_valid/cfg_ready   coefficient beat handshake
//   cfg_data, cfg_last    coefficient value, last beat of a burst
//   start, stop           streaming control pulses
//   div_val               sample period in clk cycles (0 acts as 1), taken on start
//   coeff_out/sel/we      registered write port to the coefficient bank
//   shift_en              one-cycle shift strobe to the tap shift register
//   zero_in               forces the sample input mux to zero while flushing
//   y_in                  combinational FIR result
//   y_out, y_valid        captured result and its one-cycle strobe
//   busy                  controller not idle
//   err                   sticky protocol error (start at a bad time)
// ---------------------------------------------------------------------------
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int NUM_COEFF = FIR_NUM_COEFF,
    parameter int SIZE      = FIR_SIZE,
    parameter int COEFF_W   = FIR_COEFF_W,
    parameter int SEL_W     = FIR_SEL_W,
    parameter int DIV_W     = FIR_DIV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [COEFF_W-1:0] cfg_data,
    input  logic               cfg_last,
    input  logic               start,
    input  logic               stop,
    input  logic [DIV_W-1:0]   div_val,
    output logic [SIZE-1:0]    coeff_out,
    output logic [SEL_W-1:0]   coeff_sel,
    output logic               coeff_we,
    output logic               shift_en,
    output logic               zero_in,
    input  logic [SIZE-1:0]    y_in,
    output logic [SIZE-1:0]    y_out,
    output logic               y_valid,
    output logic               busy,
    output logic               err
);

    // Flush counter must be able to hold NUM_COEFF itself.
    localparam int                FC_W      = $clog2(NUM_COEFF + 1);
    localparam logic [FC_W-1:0]   FLUSH_LEN = FC_W'(NUM_COEFF);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_COEFF - 1);

    fir_state_t        state_reg, state_next;
    logic [SEL_W-1:0]  idx_reg, idx_next;
    logic [FC_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic              err_reg, err_next;
    logic              zero_in_reg, zero_in_next;
    logic              shift_en_reg, shift_en_next;
    logic              y_valid_reg, y_valid_next;
    logic [SIZE-1:0]   y_out_reg, y_out_next;
    logic              coeff_we_reg, coeff_we_next;
    logic [SEL_W-1:0]  coeff_sel_reg, coeff_sel_next;
    logic [SIZE-1:0]   coeff_out_reg, coeff_out_next;

    logic              cfg_hs;
    logic              burst_end;
    logic              div_load;
    logic              div_en;
    logic              tick;
    logic [DIV_W-1:0]  div_reload;
    logic [SIZE-1:0]   coeff_ext;

    // Zero-extend (or truncate) the incoming coefficient to the bank width.
    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_coeff_ext
            if (gi < COEFF_W) begin : g_data
                assign coeff_ext[gi] = cfg_data[gi];
            end else begin : g_zero
                assign coeff_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign cfg_ready = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
    assign busy      = (state_reg != ST_IDLE);
    assign cfg_hs    = cfg_valid && cfg_ready;

    // A burst closes on an explicit last beat or when the final slot is hit.
    assign burst_end = cfg_last || (idx_reg == LAST_SEL);

    // div_val == 0 behaves as a period of 1 (reload value 0).
    assign div_reload = (div_val == '0) ? '0 : (div_val - DIV_W'(1));

    // The divider free-runs through RUN into FLUSH so the flush keeps the
    // streaming cadence.
    assign div_en = (state_reg == ST_RUN) || (state_reg == ST_FLUSH);

    fir_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .load_val (div_reload),
        .en       (div_en),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            flush_cnt_reg <= '0;
            err_reg       <= 1'b0;
            zero_in_reg   <= 1'b0;
            shift_en_reg  <= 1'b0;
            y_valid_reg   <= 1'b0;
            y_out_reg     <= '0;
            coeff_we_reg  <= 1'b0;
            coeff_sel_reg <= '0;
            coeff_out_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            flush_cnt_reg <= flush_cnt_next;
            err_reg       <= err_next;
            zero_in_reg   <= zero_in_next;
            shift_en_reg  <= shift_en_next;
            y_valid_reg   <= y_valid_next;
            y_out_reg     <= y_out_next;
            coeff_we_reg  <= coeff_we_next;
            coeff_sel_reg <= coeff_sel_next;
            coeff_out_reg <= coeff_out_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        flush_cnt_next = flush_cnt_reg;
        err_next       = err_reg;
        zero_in_next   = zero_in_reg;
        shift_en_next  = 1'b0;
        div_load       = 1'b0;

        // Coefficient write port: one cycle behind the handshake.
        coeff_we_next  = cfg_hs;
        coeff_sel_next = cfg_hs ? idx_reg : coeff_sel_reg;
        coeff_out_next = cfg_hs ? coeff_ext : coeff_out_reg;

        // Capture one cycle after the shift so y_in reflects the shifted taps.
        y_valid_next   = shift_en_reg;
        y_out_next     = shift_en_reg ? y_in : y_out_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cfg_hs) begin
                    // Handshake has priority; a concurrent start is dropped.
                    if (start) begin
                        err_next = 1'b1;
                    end
                    if (burst_end) begin
                        idx_next = '0;
                    end else begin
                        idx_next   = idx_reg + SEL_W'(1);
                        state_next = ST_LOAD;
                    end
                end else if (start && !stop) begin
                    div_load   = 1'b1;
                    state_next = ST_RUN;
                end
            end

            ST_LOAD: begin
                if (start) begin
                    err_next = 1'b1;
                end
                if (cfg_hs) begin
                    if (burst_end) begin
                        idx_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + SEL_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (start) begin
                    err_next = 1'b1;
                end
                // A tick coinciding with stop still shifts, as a normal sample.
                shift_en_next = tick;
                if (stop) begin
                    state_next     = ST_FLUSH;
                    zero_in_next   = 1'b1;
                    flush_cnt_next = '0;
                end
            end

            ST_FLUSH: begin
                if (start) begin
                    err_next = 1'b1;
                end
                // Stop counting ticks once NUM_COEFF zeros have been issued;
                // with a period of 1 another tick arrives before we leave.
                if (tick && (flush_cnt_reg != FLUSH_LEN)) begin
                    shift_en_next  = 1'b1;
                    flush_cnt_next = flush_cnt_reg + FC_W'(1);
                end
                // Leave on the edge that captures the last flushed result.
                if (shift_en_reg && (flush_cnt_reg == FLUSH_LEN)) begin
                    state_next   = ST_IDLE;
                    zero_in_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign coeff_out = coeff_out_reg;
    assign coeff_sel = coeff_sel_reg;
    assign coeff_we  = coeff_we_reg;
    assign shift_en  = shift_en_reg;
    assign zero_in   = zero_in_reg;
    assign y_out     = y_out_reg;
    assign y_valid   = y_valid_reg;
    assign err       = err_reg;

endmodule : fir_seq_ctrl

// File: tb/tb_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_seq_ctrl
// Scoreboard bench for fir_seq_ctrl. Stimulus tasks predict coefficient
// writes, shift strobes and result captures from the cycle numbers at which
// they issue beats/start/stop/reset, and push them into queues; a negedge
// monitor pops and compares whenever the DUT strobes an output.
// ---------------------------------------------------------------------------
module tb_fir_seq_ctrl;
    import fir_pkg::*;

    localparam int NC   = FIR_NUM_COEFF;
    localparam int SZ   = FIR_SIZE;
    localparam int CW   = FIR_COEFF_W;
    localparam int SW   = FIR_SEL_W;
    localparam int DW   = FIR_DIV_W;
    localparam int HIST = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_data;
    logic          cfg_last;
    logic          start;
    logic          stop;
    logic [DW-1:0] div_val;
    logic [SZ-1:0] coeff_out;
    logic [SW-1:0] coeff_sel;
    logic          coeff_we;
    logic          shift_en;
    logic          zero_in;
    logic [SZ-1:0] y_in;
    logic [SZ-1:0] y_out;
    logic          y_valid;
    logic          busy;
    logic          err;

    fir_seq_ctrl #(
        .NUM_COEFF (NC),
        .SIZE      (SZ),
        .COEFF_W   (CW),
        .SEL_W     (SW),
        .DIV_W     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .start     (start),
        .stop      (stop),
        .div_val   (div_val),
        .coeff_out (coeff_out),
        .coeff_sel (coeff_sel),
        .coeff_we  (coeff_we),
        .shift_en  (shift_en),
        .zero_in   (zero_in),
        .y_in      (y_in),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Expected events: cyc = cycle of the strobe, a/b = payload.
    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t wq[$];   // coefficient writes: a = slot, b = data
    ev_t sq[$];   // shifts: a = expected zero_in
    ev_t yq[$];   // captures: a = expected y_out

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   slot_m     = 0;
    int   exp_last_y = 0;
    bit   exp_err    = 1'b0;
    bit   mon_en     = 1'b0;
    ev_t  mw, ms, my;
    logic [SZ-1:0] y_hist [0:HIST-1];

    always @(posedge clk) cyc <= cyc + 1;

    // y_in changes every cycle from a pre-drawn random table.
    always @(posedge clk) begin
        #1;
        y_in = y_hist[cyc % HIST];
    end

    function automatic int yv(input int c);
        return int'(y_hist[c % HIST]);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: strobe with nothing expected (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every DUT strobe against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (coeff_we === 1'b1) begin
                if (wq.size() == 0) begin
                    unexpected("coeff_we");
                end else begin
                    mw = wq.pop_front();
                    chk("we_cycle", cyc, mw.cyc);
                    chk("we_sel", coeff_sel, mw.a);
                    chk("we_data", coeff_out, mw.b);
                    $display("[%0d] coeff write sel=%0d data=0x%02h", cyc, coeff_sel, coeff_out);
                end
            end
            if (shift_en === 1'b1) begin
                if (sq.size() == 0) begin
                    unexpected("shift_en");
                end else begin
                    ms = sq.pop_front();
                    chk("shift_cycle", cyc, ms.cyc);
                    chk("shift_zero_in", zero_in, ms.a);
                end
            end
            if (y_valid === 1'b1) begin
                if (yq.size() == 0) begin
                    unexpected("y_valid");
                end else begin
                    my = yq.pop_front();
                    chk("y_cycle", cyc, my.cyc);
                    chk("y_out", y_out, my.a);
                    $display("[%0d] sample y_out=0x%02h zero_in=%0b", cyc, y_out, zero_in);
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_coeff_out"}, coeff_out, 0);
        chk({tag, "_coeff_sel"}, coeff_sel, 0);
        chk({tag, "_coeff_we"}, coeff_we, 0);
        chk({tag, "_shift_en"}, shift_en, 0);
        chk({tag, "_zero_in"}, zero_in, 0);
        chk({tag, "_y_out"}, y_out, 0);
        chk({tag, "_y_valid"}, y_valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    // One coefficient beat in the current cycle; slot follows burst position.
    task automatic beat(input int data, input bit last);
        chk("cfg_ready_beat", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_data  = CW'(data);
        cfg_last  = last;
        wq.push_back('{cyc + 1, slot_m, data});
        slot_m = (last || slot_m == NC - 1) ? 0 : slot_m + 1;
        step();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst");
        slot_m     = 0;
        exp_err    = 1'b0;
        exp_last_y = 0;
    endtask

    // Reference timing: start seen in cycle c0 with period p (0 acts as 1)
    // -> divider events in cycles c0 + k*p (k >= 1); each gives shift_en one
    // cycle later and a capture of that cycle's y_in one cycle after that.
    // Stop in cycle s: events up to s are normal, then NC more flush events.
    // Reset in cycle r: nothing strobes after cycle r.
    task automatic plan_run(input int c0, input int d_in, input int s, input int r,
                            output int t_end);
        int p;
        int nfl;
        int t;
        p     = (d_in == 0) ? 1 : d_in;
        nfl   = 0;
        t_end = -1;
        for (int k = 1; k < 100000; k++) begin
            t = c0 + k * p;
            if (t + 1 > r) break;
            if (s >= 0 && t > s) begin
                if (nfl == NC) break;
                nfl++;
                t_end = t;
            end
            sq.push_back('{t + 1, (s >= 0 && t >= s) ? 1 : 0, 0});
            if (t + 2 <= r) begin
                yq.push_back('{t + 2, yv(t + 1), 0});
                exp_last_y = yv(t + 1);
            end
        end
    endtask

    task automatic run(input int d, input int stop_after, input int rst_after,
                       input bit start_in_run);
        int c0, s, r, t_end, end_c;
        c0 = cyc;
        s  = (stop_after > 0) ? c0 + stop_after : -1;
        r  = (rst_after > 0) ? c0 + rst_after : (1 << 30);
        plan_run(c0, d, s, r, t_end);
        div_val = DW'(d);
        start   = 1'b1;
        step();
        start   = 1'b0;
        div_val = DW'($urandom);   // only the value at start matters
        chk("busy_run", busy, 1);
        if (start_in_run) exp_err = 1'b1;
        end_c = (rst_after > 0) ? r + 1 : t_end + 2;
        while (cyc < end_c) begin
            start = (start_in_run && cyc == c0 + 2);
            stop  = (cyc == s);
            rst   = (cyc == r);
            if (rst_after == 0 && cyc == t_end + 1) begin
                chk("busy_last_flush", busy, 1);
                chk("zero_in_last_flush", zero_in, 1);
            end
            step();
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        if (rst_after > 0) begin
            check_reset_state("rst_mid");
            slot_m     = 0;
            exp_err    = 1'b0;
            exp_last_y = 0;
        end else begin
            chk("busy_done", busy, 0);
            chk("zero_in_done", zero_in, 0);
            chk("err_after_run", err, exp_err);
            step();
            chk("y_out_hold", y_out, exp_last_y);
        end
    endtask

    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < HIST; i++) y_hist[i] = SZ'($urandom);
        y_in      = '0;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        div_val   = '0;

        repeat (3) step();
        rst    = 1'b0;
        mon_en = 1'b1;
        check_reset_state("reset");

        // Full burst, valid held high, last on the 4th beat.
        beat(3, 1'b0);
        beat(5, 1'b0);
        beat(7, 1'b0);
        beat(9, 1'b1);
        step();
        chk("busy_after_burst", busy, 0);
        chk("cfg_ready_after_burst", cfg_ready, 1);

        // Short burst ends on cfg_last; next beat restarts at slot 0.
        beat(2, 1'b0);
        beat(4, 1'b1);
        chk("cfg_ready_short", cfg_ready, 1);
        chk("busy_short", busy, 0);
        beat(int'($urandom_range(0, 31)), 1'b1);
        step();

        // Random bursts with gaps and random early termination.
        for (int b = 0; b < 6; b++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 2) == 0) step();
                beat(int'($urandom_range(0, 31)), (j == len - 1) || ($urandom_range(0, 3) == 0));
            end
        end
        step();
        chk("busy_after_random_load", busy, 0);
        chk("wq_drained_load", wq.size(), 0);

        // Streaming runs.
        run(4, 14, 0, 1'b0);
        run(0, 6, 0, 1'b0);
        run(2, 7, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run(int'($urandom_range(0, 6)), int'($urandom_range(3, 25)), 0, 1'b0);
        end

        // start with stop in IDLE: stop wins, no error. stop alone ignored.
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("busy_start_stop", busy, 0);
        chk("err_start_stop", err, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("busy_stop_idle", busy, 0);

        // start during LOAD.
        beat(int'($urandom_range(0, 31)), 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_start_in_load", err, 1);
        chk("busy_still_load", busy, 1);
        beat(int'($urandom_range(0, 31)), 1'b1);
        step();
        chk("busy_load_closed", busy, 0);
        chk("err_sticky_load", err, 1);
        do_reset();

        // start together with a handshake in IDLE.
        start = 1'b1;
        beat(int'($urandom_range(0, 31)), 1'b1);
        start = 1'b0;
        chk("err_start_with_cfg", err, 1);
        chk("busy_start_dropped", busy, 0);
        repeat (3) step();
        chk("err_sticky_cfg", err, 1);
        do_reset();

        // start during RUN.
        run(3, 12, 0, 1'b1);
        do_reset();

        // Reset mid-RUN, then a fresh run re-timed from div_val.
        run(5, 0, 13, 1'b0);
        run(3, 8, 0, 1'b0);
        // Reset mid-FLUSH, then a fresh run.
        run(3, 8, 14, 1'b0);
        run(2, 5, 0, 1'b0);

        repeat (3) step();
        chk("wq_empty", wq.size(), 0);
        chk("sq_empty", sq.size(), 0);
        chk("yq_empty", yq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fir_seq_ctrl

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer for the FIR datapath (tap shift register, coefficient register bank, combinational MAC tree).
- Programs the coefficient bank through a ready/valid load port.
- Paces sample shifts with a programmable rate divider, captures y[n] with a valid strobe, and flushes the delay line with zeros on stop.
- Sits between the top-level pin decoding and the shift_register / coeffs_regs / fir instances; replaces the free-running shift enable.

Parameters:
- NUM_COEFF, 4, number of taps (coefficient slots, flush length)
- SIZE, 8, sample/coefficient/result width in bits
- COEFF_W, 5, width of incoming coefficient data; zero-extended to SIZE
- SEL_W, 2, coefficient select width; must satisfy 2**SEL_W >= NUM_COEFF
- DIV_W, 24, rate divider width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cfg_valid  in  1  coefficient beat valid
- cfg_ready  out  1  controller accepts a coefficient beat
- cfg_data  in  COEFF_W  coefficient value
- cfg_last  in  1  final beat of the load burst
- start  in  1  begin streaming (pulse)
- stop  in  1  end streaming and flush (pulse)
- div_val  in  DIV_W  sample period in clk cycles; sampled on start
- coeff_out  out  SIZE  coefficient to the bank, {zeros, cfg_data}
- coeff_sel  out  SEL_W  target coefficient slot
- coeff_we  out  1  coefficient write strobe
- shift_en  out  1  one-cycle shift strobe to the tap shift register
- zero_in  out  1  forces the sample input mux to 0 (flush)
- y_in  in  SIZE  combinational FIR result
- y_out  out  SIZE  captured result
- y_valid  out  1  one-cycle strobe; y_out updated this cycle
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error

Behaviour:
- States: IDLE=0, LOAD=1, RUN=2, FLUSH=3. All outputs are registered except cfg_ready and busy, which decode from the state.
- Reset (any state, including mid-RUN or mid-FLUSH): at the next edge, state=IDLE; coeff_out, coeff_sel, coeff_we, shift_en, zero_in, y_out, y_valid, err, divider and counters all go to 0.
- cfg_ready = 1 in IDLE and LOAD only.
- Coefficient handshake occurs on cfg_valid & cfg_ready.
  - The next cycle, coeff_we=1 with coeff_sel=idx and coeff_out=cfg_data zero-extended. coeff_we is 0 otherwise.
  - Write latency is 1 cycle.
- Load sequence:
  - First handshake in IDLE writes slot 0, then idx=1 and state goes to LOAD.
  - In LOAD, each handshake writes slot idx and increments idx.
  - The burst ends (state goes to IDLE, idx=0) on a handshake with cfg_last=1 or on the handshake to slot NUM_COEFF-1, whichever comes first. Unwritten slots keep their old values.
- start in IDLE:
  - Loads the divider with max(div_val,1)-1 and moves to RUN.
  - div_val=0 is treated as 1 (one shift per cycle).
- RUN:
  - The divider decrements each cycle. At 0, shift_en=1 for one cycle and the divider reloads.
  - The first shift_en therefore occurs max(div_val,1) cycles after the start edge.
- Result capture:
  - One cycle after shift_en, y_out <= y_in and y_valid=1 for that cycle. This covers the shift register updating on the shift_en edge.
  - y_out holds between strobes.
- stop in RUN:
  - State goes to FLUSH and zero_in=1 from the next cycle.
  - The divider keeps running without restart. NUM_COEFF further shift_en pulses are issued at the same period, and each produces a y_valid.
  - After the last pulse's capture, zero_in=0 and state goes to IDLE.
- Simultaneous events and ignored inputs:
  - stop outside RUN is ignored.
  - start during LOAD, RUN or FLUSH is ignored and sets err.
  - start with a cfg handshake in IDLE: the handshake wins, start is dropped, err is set.
  - start and stop together in IDLE: stop wins, state stays IDLE.
  - stop and the divider reaching 0 in the same RUN cycle: shift_en still fires, then FLUSH begins.
- err is cleared only by rst.
- Arithmetic is unsigned; the divider wraps never (it reloads at 0).

Decomposition:
- Package fir_pkg holds:
  - the state enum (2 bits)
  - NUM_COEFF, SIZE, COEFF_W, SEL_W defaults, shared with shift_register, coeffs_regs and fir
- One sub-module, fir_tick_gen, holds the DIV_W down-counter with load/enable, emitting a tick at 0 with auto-reload.

Test Plan:
1. Reset, then beats 3, 5, 7, 9 with cfg_valid continuously high, cfg_last on the 4th beat -> coeff_we on 4 consecutive cycles, sel 0..3, coeff_out 0x03, 0x05, 0x07, 0x09, state back to IDLE.
2. Beats 2, 4 with cfg_last on the 2nd -> only slots 0 and 1 written; cfg_ready stays 1; a subsequent beat goes to slot 0.
3. div_val=4, start -> shift_en at cycles 4, 8, 12 after start; y_valid one cycle after each with y_out equal to y_in at that cycle. div_val=0 -> shift_en every cycle.
4. stop during RUN (div_val=2) -> zero_in asserted, exactly 4 further shift_en pulses 2 cycles apart, 4 y_valid, then busy=0 and zero_in=0.
5. start during LOAD, and start together with cfg_valid in IDLE -> err=1 and stays 1. start together with stop in IDLE -> state stays IDLE, err=0.
6. rst asserted mid-RUN and mid-FLUSH -> next edge has all outputs 0, state IDLE, cfg_ready=1 once rst is deasserted; a fresh start re-times from div_val.
